spi_nor_responder: RTL and testbench
====================================

Name: spi_nor_responder

Overview:
- Device-side model of the byte-wide SPI NOR flash that the APB-to-SPI controller drives.
- Receives command, 24-bit address and data bytes on an 8-bit s_mosi bus. Returns read data or status on an 8-bit s_miso bus.
- Backs a small byte-addressed array with NOR program semantics.
- Clocked by the system p_clk. s_clk and s_css are treated as oversampled inputs.
- Used as the flash endpoint in controller system benches and as an FPGA stand-in.

Parameters:
- ADDR_W, 8: array address width; depth = 2**ADDR_W bytes; upper address bits ignored.
- ERASED, 8'hFF: array content after reset.

Ports:
- p_clk  input  1  system clock; all state on its rising edge.
- p_rst  input  1  synchronous active-high reset.
- s_clk  input  1  SPI byte clock from controller; async to p_clk, 2-flop synchronised.
- s_css  input  1  chip select, active low, 2-flop synchronised.
- s_mosi  input  8  command/address/write byte from controller.
- s_miso  output  8  read/status byte to controller.
- wel  output  1  write-enable latch state.
- cmd_err  output  1  one-cycle pulse on unsupported opcode.

Behaviour:
- Reset (p_rst=1 at a p_clk edge):
  - s_miso=0, wel=0, cmd_err=0, state=IDLE, byte count=0.
  - All array bytes = ERASED.
  - Reset mid-transaction aborts it; no partial write completes after reset.
- Edge detect:
  - rise/fall = synchronised s_clk vs its previous sample.
  - s_mosi is sampled on the p_clk cycle rise is detected.
  - s_mosi must be stable ≥3 p_clk around the s_clk rising edge.
  - s_clk high and low phases are each ≥4 p_clk.
  - Edges are ignored while synchronised s_css=1.
- Select:
  - Synchronised s_css rising forces IDLE, s_miso=0, count=0 on the next p_clk.
  - Synchronised s_css falling arms CMD.
- States: IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE.
- CMD (first byte captured on rise):
  - 0x03 → ADDR (read).
  - 0x02 → ADDR (program) if wel=1, else IGNORE.
  - 0x06 → wel=1, then IGNORE.
  - 0x04 → wel=0, then IGNORE.
  - 0x05 → STATUS.
  - Any other value → cmd_err pulse for 1 cycle, then IGNORE.
- ADDR:
  - Three bytes, MSB first, into a 24-bit shift register.
  - After the third rise: addr = low ADDR_W bits; go to RD_DATA or WR_DATA.
- RD_DATA:
  - On each detected fall: s_miso = mem[addr].
  - On each rise: addr = addr+1, wrapping from 2**ADDR_W-1 to 0.
  - The first byte is therefore valid at the controller's next s_clk rise after the last address byte.
- WR_DATA:
  - On each rise: mem[addr] = mem[addr] & s_mosi (NOR program: bits clear only), then addr = addr+1 with wrap.
  - Transaction end (s_css rise) after ≥1 data byte clears wel.
  - Bytes already written stay written on early deselect.
- STATUS:
  - On each fall: s_miso = {6'b0, wel, 1'b0}.
  - Bit0 (WIP) is always 0; programming is instantaneous.
- IGNORE: s_mosi discarded and s_miso held at 0 until deselect.
- Simultaneous events:
  - p_rst beats everything.
  - s_css rise beats an edge detected in the same cycle; that edge is dropped.
- s_miso is 0 in every state except RD_DATA and STATUS.
- Writes never change wel except via 0x06, 0x04, or program end.

Test Plan:
- Reset then read: 0x03, 00,00,10, 4 dummy bytes → s_miso returns FF,FF,FF,FF; wel=0.
- Program without WREN: 0x02, 00,00,10, A5 → array unchanged; readback at 0x10 = FF; cmd_err=0.
- WREN then program: 0x06, deselect; 0x02, 00,00,10, A5,3C → wel=1 between transactions, 0 after. Readback at 0x10,0x11 = A5,3C.
- NOR AND semantics: WREN; program 0x10 with 0F after A5 → readback 05.
- Wrap: WREN; program at 00,00,FF with 11,22 → mem[FF]=11, mem[00]=22. Read from 0xFF for 2 bytes → 11,22. Address 0xAB_CD_FF maps identically.
- Status, error and abort:
  - 0x06, then 0x05 + 2 dummy bytes → 02,02.
  - 0x9F → cmd_err pulses once and s_miso stays 0.
  - s_css high mid-read → s_miso=0 within 3 p_clk.
  - p_rst during WR_DATA → array = FF, wel=0.

Source files
------------

// File: rtl/spi_nor_responder_if.sv
// Byte-wide SPI link between the flash controller (master) and the NOR responder (slave).
// Carries the oversampled clock/select, both data bytes and the responder's status outputs.
interface spi_nor_responder_if;
  logic       s_clk;
  logic       s_css;
  logic [7:0] s_mosi;
  logic [7:0] s_miso;
  logic       wel;
  logic       cmd_err;

  modport master (
    output s_clk, s_css, s_mosi,
    input  s_miso, wel, cmd_err
  );

  modport slave (
    input  s_clk, s_css, s_mosi,
    output s_miso, wel, cmd_err
  );
endinterface

// File: rtl/spi_nor_responder.sv
// Byte-wide SPI NOR flash responder; s_clk/s_css 2-flop synchronised, outputs registered 1 cycle after the detected edge.
// No backpressure: the controller paces bytes via s_clk, which must keep >=4 p_clk per phase.
module spi_nor_responder #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  ERASED = 8'hFF
) (
  input  logic               p_clk,
  input  logic               p_rst,
  spi_nor_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_STATUS,
    S_IGNORE
  } state_t;

  logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic              r_css_s1, r_css_s2, r_css_d;
  state_t            r_state;
  logic [7:0]        r_miso;
  logic              r_wel;
  logic              r_cmd_err;
  logic              r_is_wr;
  logic              r_wr_seen;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_mem [DEPTH];

  logic              w_rise;
  logic              w_fall;
  logic              w_css_rise;
  logic              w_css_fall;
  logic [ADDR_W-1:0] w_addr_shift;

  assign w_rise     =  r_sclk_s2 & ~r_sclk_d & ~r_css_s2;
  assign w_fall     = ~r_sclk_s2 &  r_sclk_d & ~r_css_s2;
  assign w_css_rise =  r_css_s2 & ~r_css_d;
  assign w_css_fall = ~r_css_s2 &  r_css_d;

  // Only the low ADDR_W bits of the 24-bit address matter, so bytes shift straight into r_addr.
  assign w_addr_shift = ADDR_W'({r_addr, bus.s_mosi});

  assign bus.s_miso  = r_miso;
  assign bus.wel     = r_wel;
  assign bus.cmd_err = r_cmd_err;

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      r_sclk_s1  <= 1'b0;
      r_sclk_s2  <= 1'b0;
      r_sclk_d   <= 1'b0;
      r_css_s1   <= 1'b1;
      r_css_s2   <= 1'b1;
      r_css_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_miso     <= 8'h00;
      r_wel      <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_is_wr    <= 1'b0;
      r_wr_seen  <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_addr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= ERASED;
      end
    end else begin
      r_sclk_s1 <= bus.s_clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_css_s1  <= bus.s_css;
      r_css_s2  <= r_css_s1;
      r_css_d   <= r_css_s2;
      r_cmd_err <= 1'b0;

      // Deselect wins over any s_clk edge seen in the same cycle.
      if (w_css_rise) begin
        if (r_state == S_WR_DATA && r_wr_seen) begin
          r_wel <= 1'b0;
        end
        r_state    <= S_IDLE;
        r_miso     <= 8'h00;
        r_byte_cnt <= 2'd0;
        r_wr_seen  <= 1'b0;
      end else if (w_css_fall) begin
        r_state    <= S_CMD;
        r_miso     <= 8'h00;
        r_byte_cnt <= 2'd0;
        r_wr_seen  <= 1'b0;
      end else begin
        case (r_state)
          S_CMD: begin
            if (w_rise) begin
              case (bus.s_mosi)
                8'h03: begin
                  r_is_wr <= 1'b0;
                  r_state <= S_ADDR;
                end
                8'h02: begin
                  r_is_wr <= 1'b1;
                  r_state <= r_wel ? S_ADDR : S_IGNORE;
                end
                8'h06: begin
                  r_wel   <= 1'b1;
                  r_state <= S_IGNORE;
                end
                8'h04: begin
                  r_wel   <= 1'b0;
                  r_state <= S_IGNORE;
                end
                8'h05: r_state <= S_STATUS;
                default: begin
                  r_cmd_err <= 1'b1;
                  r_state   <= S_IGNORE;
                end
              endcase
            end
          end

          S_ADDR: begin
            if (w_rise) begin
              r_addr <= w_addr_shift;
              if (r_byte_cnt == 2'd2) begin
                r_byte_cnt <= 2'd0;
                r_state    <= r_is_wr ? S_WR_DATA : S_RD_DATA;
              end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
              end
            end
          end

          // Data is presented on the fall so it is settled for the controller's next rise.
          S_RD_DATA: begin
            if (w_fall) begin
              r_miso <= r_mem[r_addr];
            end else if (w_rise) begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end

          S_WR_DATA: begin
            if (w_rise) begin
              r_mem[r_addr] <= r_mem[r_addr] & bus.s_mosi;
              r_addr        <= r_addr + ADDR_W'(1);
              r_wr_seen     <= 1'b1;
            end
          end

          S_STATUS: begin
            if (w_fall) begin
              r_miso <= {6'b0, r_wel, 1'b0};
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_nor_responder.sv
// Bench for spi_nor_responder: directed plan plus random transactions against a
// transaction-level model (byte array + wel bit).
module tb_spi_nor_responder;

  logic p_clk = 1'b0;
  logic p_rst;

  spi_nor_responder_if bus();

  spi_nor_responder #(.ADDR_W(8), .ERASED(8'hFF)) dut (
    .p_clk (p_clk),
    .p_rst (p_rst),
    .bus   (bus)
  );

  always #5 p_clk = ~p_clk;

  int n_checks   = 0;
  int n_errors   = 0;
  int err_pulses = 0;

  byte unsigned ref_mem [256];
  bit           ref_wel;
  byte unsigned tx_q [$];
  logic [7:0]   rx_q [$];
  byte unsigned exp_q [$];
  int           exp_err;

  always @(posedge p_clk) begin
    if (bus.cmd_err === 1'b1) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge p_clk);
    #1;
  endtask

  task automatic xfer(input byte unsigned b, output logic [7:0] m);
    bus.s_mosi = b;
    tick(4);
    m = bus.s_miso;
    bus.s_clk = 1'b1;
    tick(6);
    bus.s_clk = 1'b0;
    tick(6);
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'hFF;
    ref_wel = 1'b0;
  endtask

  // Expected miso per byte and the model update, straight from the command rules.
  task automatic model_txn();
    int n;
    int a;
    n = tx_q.size();
    exp_q = {};
    exp_err = 0;
    for (int k = 0; k < n; k++) exp_q.push_back(8'h00);
    a = (n >= 4) ? int'(tx_q[3]) : 0;
    case (tx_q[0])
      8'h03: for (int k = 4; k < n; k++) exp_q[k] = ref_mem[(a + k - 4) % 256];
      8'h02: if (ref_wel) begin
        for (int k = 4; k < n; k++) ref_mem[(a + k - 4) % 256] &= tx_q[k];
        if (n > 4) ref_wel = 1'b0;
      end
      8'h06: ref_wel = 1'b1;
      8'h04: ref_wel = 1'b0;
      8'h05: for (int k = 1; k < n; k++) exp_q[k] = {6'b0, ref_wel, 1'b0};
      default: exp_err = 1;
    endcase
  endtask

  task automatic do_txn(input string tag);
    int e0;
    logic [7:0] m;
    model_txn();
    e0 = err_pulses;
    rx_q = {};
    bus.s_css = 1'b0;
    tick(6);
    foreach (tx_q[k]) begin
      xfer(tx_q[k], m);
      rx_q.push_back(m);
    end
    bus.s_css = 1'b1;
    tick(6);
    foreach (exp_q[k]) check($sformatf("%s miso[%0d]", tag, k), rx_q[k], exp_q[k]);
    check({tag, " cmd_err"}, err_pulses - e0, exp_err);
    check({tag, " wel"}, bus.wel, ref_wel);
    check({tag, " idle miso"}, bus.s_miso, 8'h00);
  endtask

  initial begin
    logic [7:0] m;
    int op_sel;
    int ndat;

    bus.s_clk  = 1'b0;
    bus.s_css  = 1'b1;
    bus.s_mosi = 8'h00;
    p_rst = 1'b1;
    tick(3);
    p_rst = 1'b0;
    ref_reset();
    tick(1);
    check("rst miso", bus.s_miso, 8'h00);
    check("rst wel", bus.wel, 1'b0);
    check("rst cmd_err", bus.cmd_err, 1'b0);

    tx_q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}; do_txn("read_erased");
    tx_q = {8'h02, 8'h00, 8'h00, 8'h10, 8'hA5};                      do_txn("prog_no_wren");
    tx_q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00};                      do_txn("rb_no_wren");
    tx_q = {8'h06};                                                  do_txn("wren1");
    tx_q = {8'h02, 8'h00, 8'h00, 8'h10, 8'hA5, 8'h3C};               do_txn("prog_a5_3c");
    tx_q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};               do_txn("rb_a5_3c");
    tx_q = {8'h06};                                                  do_txn("wren2");
    tx_q = {8'h02, 8'h00, 8'h00, 8'h10, 8'h0F};                      do_txn("prog_and");
    tx_q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00};                      do_txn("rb_and");
    tx_q = {8'h06};                                                  do_txn("wren3");
    tx_q = {8'h02, 8'h00, 8'h00, 8'hFF, 8'h11, 8'h22};               do_txn("prog_wrap");
    tx_q = {8'h03, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};               do_txn("rb_wrap");
    tx_q = {8'h03, 8'hAB, 8'hCD, 8'hFF, 8'h00, 8'h00};               do_txn("rb_wrap_hi");
    tx_q = {8'h06};                                                  do_txn("wren4");
    tx_q = {8'h05, 8'h00, 8'h00};                                    do_txn("status_wel");
    tx_q = {8'h9F, 8'h00, 8'h00};                                    do_txn("bad_op");
    tx_q = {8'h04};                                                  do_txn("wrdi");
    tx_q = {8'h05, 8'h00};                                           do_txn("status_nowel");

    for (int t = 0; t < 60; t++) begin
      op_sel = $urandom_range(0, 6);
      ndat = $urandom_range(0, 4);
      case (op_sel)
        0, 1: tx_q = {8'h03};
        2, 3: tx_q = {8'h02};
        4:    tx_q = {($urandom_range(0, 1) != 0) ? 8'h06 : 8'h04};
        5:    tx_q = {8'h05};
        default: tx_q = {8'($urandom_range(0, 255))};
      endcase
      if (tx_q[0] == 8'h03 || tx_q[0] == 8'h02) begin
        for (int k = 0; k < 3; k++) tx_q.push_back(8'($urandom));
      end
      for (int k = 0; k < ndat; k++) tx_q.push_back(8'($urandom | $urandom));
      do_txn($sformatf("rnd%0d", t));
    end

    // Reset in the middle of a program: everything back to erased, wel clear.
    tx_q = {8'h06}; do_txn("wren_rst");
    bus.s_css = 1'b0;
    tick(6);
    xfer(8'h02, m); xfer(8'h00, m); xfer(8'h00, m); xfer(8'h20, m); xfer(8'h00, m);
    bus.s_mosi = 8'h00;
    tick(2);
    p_rst = 1'b1;
    tick(1);
    p_rst = 1'b0;
    ref_reset();
    tick(1);
    check("rst_mid wel", bus.wel, 1'b0);
    check("rst_mid miso", bus.s_miso, 8'h00);
    bus.s_css = 1'b1;
    tick(6);
    tx_q = {8'h03, 8'h00, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00}; do_txn("rb_after_rst");
    tx_q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00};                      do_txn("rb_after_rst2");

    // Deselect mid-read must blank s_miso within 3 p_clk.
    bus.s_css = 1'b0;
    tick(6);
    xfer(8'h03, m); xfer(8'h00, m); xfer(8'h00, m); xfer(8'h40, m);
    xfer(8'h00, m);
    check("abort first byte", m, 8'hFF);
    check("abort loaded", bus.s_miso, 8'hFF);
    bus.s_css = 1'b1;
    tick(3);
    check("abort miso", bus.s_miso, 8'h00);
    tick(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
